// File: rtl/sdc_cmd_responder_if.sv
// Card-logic side of the SD CMD-line responder: decoded command, status return and event pulses.
`timescale 1ns/1ps
interface sdc_cmd_responder_if;
  logic        cmd_valid_o;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_arg_o;
  logic [31:0] resp_status_i;
  logic        crc_err_o;
  logic        frame_err_o;
  logic        busy_o;

  modport slave (
    output cmd_valid_o, cmd_index_o, cmd_arg_o, crc_err_o, frame_err_o, busy_o,
    input  resp_status_i
  );

  modport master (
    input  cmd_valid_o, cmd_index_o, cmd_arg_o, crc_err_o, frame_err_o, busy_o,
    output resp_status_i
  );
endinterface

// File: rtl/sdc_cmd_responder.sv
// Card-side SD CMD-line responder: receives 48-bit commands, answers with R1 after NCR clocks.
// Define SDC_RESP_CRC_CHECK_EN to reject commands whose CRC7 does not match.
`timescale 1ns/1ps
module sdc_cmd_responder #(
  parameter int unsigned NCR         = 2,
  parameter logic [5:0]  NO_RESP_IDX = 6'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_i,
  output logic                cmd_o,
  output logic                cmd_oe,
  sdc_cmd_responder_if.slave  card
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_CHECK,
    ST_WAIT,
    ST_TX
  } state_t;

  localparam logic [5:0] NcrLoad = 6'(NCR - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [6:0]  crc_q, crc_d;
  logic [37:0] rxShift_q, rxShift_d;
  logic [39:0] txShift_q, txShift_d;
  logic [5:0]  index_q, index_d;
  logic [31:0] arg_q, arg_d;
  logic        valid_q, valid_d;
  logic        frameErr_q, frameErr_d;
  logic        crcOk;

`ifdef SDC_RESP_CRC_CHECK_EN
  logic [6:0]  rxCrc_q, rxCrc_d;
  logic        crcErr_q, crcErr_d;
`endif

  // Serial CRC7, generator x^7 + x^3 + 1
  function automatic logic [6:0] crc7Step(input logic [6:0] crc, input logic bitIn);
    logic fb;
    fb = crc[6] ^ bitIn;
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

`ifdef SDC_RESP_CRC_CHECK_EN
  assign crcOk = (rxCrc_q == crc_q);
`else
  assign crcOk = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      crc_q      <= '0;
      rxShift_q  <= '0;
      txShift_q  <= '0;
      index_q    <= '0;
      arg_q      <= '0;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
`ifdef SDC_RESP_CRC_CHECK_EN
      rxCrc_q    <= '0;
      crcErr_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      rxShift_q  <= rxShift_d;
      txShift_q  <= txShift_d;
      index_q    <= index_d;
      arg_q      <= arg_d;
      valid_q    <= valid_d;
      frameErr_q <= frameErr_d;
`ifdef SDC_RESP_CRC_CHECK_EN
      rxCrc_q    <= rxCrc_d;
      crcErr_q   <= crcErr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    rxShift_d  = rxShift_q;
    txShift_d  = txShift_q;
    index_d    = index_q;
    arg_d      = arg_q;
    valid_d    = 1'b0;
    frameErr_d = 1'b0;
`ifdef SDC_RESP_CRC_CHECK_EN
    rxCrc_d    = rxCrc_q;
    crcErr_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (!cmd_i) begin
          state_d = ST_RX;
          cnt_d   = 6'd46;
          crc_d   = '0;
        end
      end

      // cnt_q is the frame bit number being sampled this cycle
      ST_RX: begin
        if (cnt_q >= 6'd8) begin
          crc_d     = crc7Step(crc_q, cmd_i);
          rxShift_d = {rxShift_q[36:0], cmd_i};
        end
`ifdef SDC_RESP_CRC_CHECK_EN
        if (cnt_q != 6'd0 && cnt_q < 6'd8) begin
          rxCrc_d = {rxCrc_q[5:0], cmd_i};
        end
`endif
        if (cnt_q == 6'd46 && !cmd_i) begin
          frameErr_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q == 6'd0) begin
          if (!cmd_i) begin
            frameErr_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_CHECK;
            if (crcOk) begin
              valid_d = 1'b1;
              index_d = rxShift_q[37:32];
              arg_d   = rxShift_q[31:0];
            end else begin
`ifdef SDC_RESP_CRC_CHECK_EN
              crcErr_d = 1'b1;
`endif
            end
          end
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      ST_CHECK: begin
        if (valid_q && index_q != NO_RESP_IDX) begin
          state_d   = ST_WAIT;
          cnt_d     = NcrLoad;
          txShift_d = {2'b00, index_q, card.resp_status_i};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (cnt_q == 6'd0) begin
          state_d = ST_TX;
          cnt_d   = 6'd47;
          crc_d   = '0;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      // Bits 47..8 come from txShift_q, 7..1 from the running CRC, bit 0 is the end bit
      ST_TX: begin
        if (cnt_q >= 6'd8) begin
          crc_d     = crc7Step(crc_q, txShift_q[39]);
          txShift_d = {txShift_q[38:0], 1'b0};
        end else if (cnt_q != 6'd0) begin
          crc_d = {crc_q[5:0], 1'b0};
        end
        if (cnt_q == 6'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_o = 1'b1;
    if (state_q == ST_TX) begin
      if (cnt_q >= 6'd8) begin
        cmd_o = txShift_q[39];
      end else if (cnt_q != 6'd0) begin
        cmd_o = crc_q[6];
      end
    end
  end

  assign cmd_oe           = (state_q == ST_TX);
  assign card.busy_o      = (state_q != ST_IDLE);
  assign card.cmd_valid_o = valid_q;
  assign card.cmd_index_o = index_q;
  assign card.cmd_arg_o   = arg_q;
  assign card.frame_err_o = frameErr_q;
`ifdef SDC_RESP_CRC_CHECK_EN
  assign card.crc_err_o   = crcErr_q;
`else
  assign card.crc_err_o   = 1'b0;
`endif

endmodule
